// File: rtl/mac_psum_issuer.sv
// MAC psum producer: reduces LANES signed products per beat to one psum tagged with inter/accum end flags.
// Define MAC_PSUM_ISSUER_PIPE_EN to split the adder tree with an extra register stage (latency 2).
module mac_psum_issuer #(
  parameter int LANES  = 16,
  parameter int IN_W   = 16,
  parameter int PSUM_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                    mac_psum_issuer_i_clk,
  input  logic                    mac_psum_issuer_i_reset_n,
  input  logic                    mac_psum_issuer_i_cfg_start,
  input  logic [CNT_W-1:0]        mac_psum_issuer_i_cfg_inter_len,
  input  logic [CNT_W-1:0]        mac_psum_issuer_i_cfg_accum_len,
  output logic                    mac_psum_issuer_o_busy,
  input  logic                    mac_psum_issuer_i_prod_valid,
  output logic                    mac_psum_issuer_o_prod_ready,
  input  logic [LANES*IN_W-1:0]   mac_psum_issuer_i_prod_data,
  output logic                    mac_psum_issuer_o_psum_valid,
  input  logic                    mac_psum_issuer_i_psum_ready,
  output logic [PSUM_W-1:0]       mac_psum_issuer_o_psum_data,
  output logic                    mac_psum_issuer_o_inter_end,
  output logic                    mac_psum_issuer_o_accum_end
);
  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_nxt_s;
  logic              run_s, busy_s, start_s, accept_s, prod_ready_s;
  logic              out_move_s, load_ok_s, inter_tag_s, accum_tag_s;
  logic [CNT_W-1:0]  inter_len_r, accum_len_r, inter_cnt_r, seg_cnt_r;
  logic              out_valid_r, out_inter_r, out_accum_r;
  logic [PSUM_W-1:0] out_data_r;

  function automatic logic [PSUM_W-1:0] sext_lane(input logic [LANES*IN_W-1:0] data, input int idx);
    logic [IN_W-1:0] lane;
    lane = data[idx*IN_W +: IN_W];
    return {{(PSUM_W-IN_W){lane[IN_W-1]}}, lane};
  endfunction

  assign out_move_s   = !out_valid_r || mac_psum_issuer_i_psum_ready;
  assign start_s      = mac_psum_issuer_i_cfg_start && !busy_s;
  assign accept_s     = mac_psum_issuer_i_prod_valid && prod_ready_s;
  assign inter_tag_s  = (inter_cnt_r == (inter_len_r - CNT_ONE));
  assign accum_tag_s  = inter_tag_s && (seg_cnt_r == (accum_len_r - CNT_ONE));

  // FSM state register
  always_ff @(posedge mac_psum_issuer_i_clk or negedge mac_psum_issuer_i_reset_n) begin
    if (!mac_psum_issuer_i_reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_nxt_s = RUN;
        else         state_nxt_s = IDLE;
      end
      RUN: begin
        if (accept_s && accum_tag_s) state_nxt_s = IDLE;
        else                         state_nxt_s = RUN;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    run_s        = (state_r == RUN);
    prod_ready_s = run_s && load_ok_s;
  end

  // Latched lengths and beat/segment counters
  always_ff @(posedge mac_psum_issuer_i_clk or negedge mac_psum_issuer_i_reset_n) begin
    if (!mac_psum_issuer_i_reset_n) begin
      inter_len_r <= CNT_ZERO;
      accum_len_r <= CNT_ZERO;
      inter_cnt_r <= CNT_ZERO;
      seg_cnt_r   <= CNT_ZERO;
    end else if (start_s) begin
      inter_len_r <= (mac_psum_issuer_i_cfg_inter_len == CNT_ZERO) ? CNT_ONE : mac_psum_issuer_i_cfg_inter_len;
      accum_len_r <= (mac_psum_issuer_i_cfg_accum_len == CNT_ZERO) ? CNT_ONE : mac_psum_issuer_i_cfg_accum_len;
      inter_cnt_r <= CNT_ZERO;
      seg_cnt_r   <= CNT_ZERO;
    end else if (accept_s) begin
      if (accum_tag_s) begin
        inter_cnt_r <= CNT_ZERO;
        seg_cnt_r   <= CNT_ZERO;
      end else if (inter_tag_s) begin
        inter_cnt_r <= CNT_ZERO;
        seg_cnt_r   <= seg_cnt_r + CNT_ONE;
      end else begin
        inter_cnt_r <= inter_cnt_r + CNT_ONE;
      end
    end
  end

`ifdef MAC_PSUM_ISSUER_PIPE_EN
  // First half of the tree reduces groups of GRP lanes; the second half sums the groups.
  localparam int HALF_LVL = $clog2(LANES) / 2;
  localparam int GRP      = 1 << HALF_LVL;
  localparam int NGRP     = LANES / GRP;

  logic [PSUM_W-1:0] grp_sum_s [NGRP];
  logic [PSUM_W-1:0] s1_psum_r [NGRP];
  logic [PSUM_W-1:0] final_sum_s;
  logic              s1_valid_r, s1_inter_r, s1_accum_r, s1_move_s;

  assign s1_move_s = !s1_valid_r || out_move_s;
  assign load_ok_s = s1_move_s;
  assign busy_s    = run_s || s1_valid_r || out_valid_r;

  // Group partial sums from the raw lanes
  always_comb begin
    for (int g = 0; g < NGRP; g++) begin
      grp_sum_s[g] = {PSUM_W{1'b0}};
      for (int i = 0; i < GRP; i++) begin
        grp_sum_s[g] = grp_sum_s[g] + sext_lane(mac_psum_issuer_i_prod_data, g*GRP + i);
      end
    end
  end

  // Final reduction of the registered group sums
  always_comb begin
    final_sum_s = {PSUM_W{1'b0}};
    for (int g = 0; g < NGRP; g++) begin
      final_sum_s = final_sum_s + s1_psum_r[g];
    end
  end

  // Mid-tree register stage with its flags
  always_ff @(posedge mac_psum_issuer_i_clk or negedge mac_psum_issuer_i_reset_n) begin
    if (!mac_psum_issuer_i_reset_n) begin
      s1_valid_r <= 1'b0;
      s1_inter_r <= 1'b0;
      s1_accum_r <= 1'b0;
      for (int g = 0; g < NGRP; g++) s1_psum_r[g] <= {PSUM_W{1'b0}};
    end else if (s1_move_s) begin
      s1_valid_r <= accept_s;
      s1_inter_r <= accept_s && inter_tag_s;
      s1_accum_r <= accept_s && accum_tag_s;
      if (accept_s) begin
        for (int g = 0; g < NGRP; g++) s1_psum_r[g] <= grp_sum_s[g];
      end
    end
  end

  // Output register fed from the mid-tree stage
  always_ff @(posedge mac_psum_issuer_i_clk or negedge mac_psum_issuer_i_reset_n) begin
    if (!mac_psum_issuer_i_reset_n) begin
      out_valid_r <= 1'b0;
      out_inter_r <= 1'b0;
      out_accum_r <= 1'b0;
      out_data_r  <= {PSUM_W{1'b0}};
    end else if (out_move_s) begin
      out_valid_r <= s1_valid_r;
      out_inter_r <= s1_valid_r && s1_inter_r;
      out_accum_r <= s1_valid_r && s1_accum_r;
      if (s1_valid_r) out_data_r <= final_sum_s;
    end
  end
`else
  logic [PSUM_W-1:0] sum_s;

  assign load_ok_s = out_move_s;
  assign busy_s    = run_s || out_valid_r;

  // Full adder tree over all lanes
  always_comb begin
    sum_s = {PSUM_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      sum_s = sum_s + sext_lane(mac_psum_issuer_i_prod_data, i);
    end
  end

  // Output register: drain and refill in the same cycle is allowed
  always_ff @(posedge mac_psum_issuer_i_clk or negedge mac_psum_issuer_i_reset_n) begin
    if (!mac_psum_issuer_i_reset_n) begin
      out_valid_r <= 1'b0;
      out_inter_r <= 1'b0;
      out_accum_r <= 1'b0;
      out_data_r  <= {PSUM_W{1'b0}};
    end else if (out_move_s) begin
      out_valid_r <= accept_s;
      out_inter_r <= accept_s && inter_tag_s;
      out_accum_r <= accept_s && accum_tag_s;
      if (accept_s) out_data_r <= sum_s;
    end
  end
`endif

  assign mac_psum_issuer_o_busy       = busy_s;
  assign mac_psum_issuer_o_prod_ready = prod_ready_s;
  assign mac_psum_issuer_o_psum_valid = out_valid_r;
  assign mac_psum_issuer_o_psum_data  = out_data_r;
  assign mac_psum_issuer_o_inter_end  = out_inter_r;
  assign mac_psum_issuer_o_accum_end  = out_accum_r;

endmodule

// File: tb/tb_mac_psum_issuer.sv
// Directed self-checking bench for mac_psum_issuer: flag placement, stalls, config locking, reset mid-job.
// Expected psums/flags are derived from beat indices and the programmed lengths.
module tb_mac_psum_issuer;
  localparam int LANES  = 16;
  localparam int IN_W   = 16;
  localparam int PSUM_W = 32;
  localparam int CNT_W  = 16;
`ifdef MAC_PSUM_ISSUER_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  cfg_start;
  logic [CNT_W-1:0]      cfg_inter_len, cfg_accum_len;
  logic                  busy;
  logic                  prod_valid, prod_ready;
  logic [LANES*IN_W-1:0] prod_data;
  logic                  psum_valid, psum_ready;
  logic [PSUM_W-1:0]     psum_data;
  logic                  inter_end, accum_end;

  typedef struct packed {
    logic [31:0] d;
    logic        ie;
    logic        ae;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mac_psum_issuer #(.LANES(LANES), .IN_W(IN_W), .PSUM_W(PSUM_W), .CNT_W(CNT_W)) dut (
    .mac_psum_issuer_i_clk           (clk),
    .mac_psum_issuer_i_reset_n       (rst_n),
    .mac_psum_issuer_i_cfg_start     (cfg_start),
    .mac_psum_issuer_i_cfg_inter_len (cfg_inter_len),
    .mac_psum_issuer_i_cfg_accum_len (cfg_accum_len),
    .mac_psum_issuer_o_busy          (busy),
    .mac_psum_issuer_i_prod_valid    (prod_valid),
    .mac_psum_issuer_o_prod_ready    (prod_ready),
    .mac_psum_issuer_i_prod_data     (prod_data),
    .mac_psum_issuer_o_psum_valid    (psum_valid),
    .mac_psum_issuer_i_psum_ready    (psum_ready),
    .mac_psum_issuer_o_psum_data     (psum_data),
    .mac_psum_issuer_o_inter_end     (inter_end),
    .mac_psum_issuer_o_accum_end     (accum_end)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic got, input logic exp);
    chk(tag, {31'd0, got}, {31'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare an output handshake against the oldest expected psum
  task automatic mon();
    exp_t e;
    if (psum_valid && psum_ready) begin
      if (q.size() == 0) begin
        chk("extra_psum", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("psum_data", psum_data, e.d);
        chk_b("inter_end", inter_end, e.ie);
        chk_b("accum_end", accum_end, e.ae);
      end
    end
  endtask

  // Send n beats (job indices j0..j0+n-1); every lane of beat j carries base + j*step
  task automatic stream(input int j0, input int n, input int base, input int step, input int il, input int al);
    int sent;
    int lane;
    int j;
    logic [IN_W-1:0] l16;
    sent = 0;
    prod_valid = 1'b1;
    for (int c = 0; c < 100 && sent < n; c++) begin
      j    = j0 + sent;
      lane = base + j * step;
      l16  = lane[IN_W-1:0];
      prod_data = {LANES{l16}};
      #1;
      mon();
      if (prod_valid && prod_ready) begin
        q.push_back('{d: 32'(LANES * lane), ie: ((j % il) == 0), ae: ((j % (il * al)) == 0)});
        sent++;
      end
      tick();
    end
    prod_valid = 1'b0;
    chk("beats_accepted", 32'(sent), 32'(n));
  endtask

  task automatic drain();
    for (int c = 0; c < 40; c++) begin
      #1;
      mon();
      if (!busy) break;
      tick();
    end
    chk_b("drained_busy", busy, 1'b0);
    chk("queue_empty", 32'(q.size()), 32'd0);
    tick();
  endtask

  task automatic start_job(input logic [CNT_W-1:0] il, input logic [CNT_W-1:0] al);
    cfg_inter_len = il;
    cfg_accum_len = al;
    cfg_start = 1'b1;
    #1;
    mon();
    tick();
    cfg_start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cfg_start = 1'b0;
    cfg_inter_len = 16'd0;
    cfg_accum_len = 16'd0;
    prod_valid = 1'b0;
    prod_data = {(LANES*IN_W){1'b0}};
    psum_ready = 1'b1;
    tick();
    tick();
    chk_b("rst_psum_valid", psum_valid, 1'b0);
    chk("rst_psum_data", psum_data, 32'd0);
    chk_b("rst_inter_end", inter_end, 1'b0);
    chk_b("rst_accum_end", accum_end, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_prod_ready", prod_ready, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: 8 beats of ones, inter_len=4 accum_len=2; a start held across the drain is ignored
    start_job(16'd4, 16'd2);
    chk_b("t1_busy_run", busy, 1'b1);
    chk_b("t1_ready_run", prod_ready, 1'b1);
    stream(1, 8, 1, 0, 4, 2);
    chk_b("t1_busy_after_last", busy, 1'b1);
    cfg_inter_len = 16'd1;
    cfg_accum_len = 16'd1;
    cfg_start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (!busy) break;
      mon();
      tick();
    end
    cfg_start = 1'b0;
    #1;
    chk_b("t1_idle_ready", prod_ready, 1'b0);
    chk_b("t1_idle_busy", busy, 1'b0);
    tick();
    chk_b("t1_start_ignored", prod_ready, 1'b0);
    chk("t1_queue_empty", 32'(q.size()), 32'd0);

    // 2: all lanes -32768, single-beat job, latency check
    start_job(16'd1, 16'd1);
    prod_data = {LANES{16'h8000}};
    prod_valid = 1'b1;
    #1;
    chk_b("t2_ready", prod_ready, 1'b1);
    q.push_back('{d: 32'hFFF8_0000, ie: 1'b1, ae: 1'b1});
    tick();
    prod_valid = 1'b0;
    for (int c = 1; c < LAT; c++) begin
      #1;
      chk_b("t2_lat_early", psum_valid, 1'b0);
      tick();
    end
    #1;
    chk_b("t2_valid", psum_valid, 1'b1);
    chk("t2_data", psum_data, 32'hFFF8_0000);
    chk_b("t2_inter", inter_end, 1'b1);
    chk_b("t2_accum", accum_end, 1'b1);
    chk_b("t2_idle_ready", prod_ready, 1'b0);
    drain();

    // 3: ready low for 5 cycles mid-stream, inter_len=3 accum_len=2
    start_job(16'd3, 16'd2);
    stream(1, 2, 0, 1, 3, 2);
    psum_ready = 1'b0;
    prod_valid = 1'b1;
    prod_data = {LANES{16'd3}};
    for (int c = 0; c < 5; c++) begin
      #1;
      chk_b("t3_stall_valid", psum_valid, 1'b1);
      chk("t3_stall_data", psum_data, 32'(16 * (3 - LAT)));
      chk_b("t3_stall_inter", inter_end, 1'b0);
      chk_b("t3_stall_accum", accum_end, 1'b0);
      chk_b("t3_stall_ready", prod_ready, 1'b0);
      mon();
      tick();
    end
    psum_ready = 1'b1;
    stream(3, 4, 0, 1, 3, 2);
    drain();

    // 4: restart attempt with other lengths mid-job is ignored
    start_job(16'd2, 16'd2);
    stream(1, 1, 0, 1, 2, 2);
    cfg_inter_len = 16'd1;
    cfg_accum_len = 16'd1;
    cfg_start = 1'b1;
    #1;
    mon();
    tick();
    cfg_start = 1'b0;
    chk_b("t4_still_run", prod_ready, 1'b1);
    stream(2, 3, 0, 1, 2, 2);
    drain();

    // 5: zero lengths -> one beat per job, both flags set
    start_job(16'd0, 16'd0);
    stream(1, 1, 5, 0, 1, 1);
    prod_valid = 1'b1;
    #1;
    chk_b("t5_single_beat", prod_ready, 1'b0);
    mon();
    prod_valid = 1'b0;
    tick();
    drain();
    start_job(16'd0, 16'd0);
    stream(1, 1, -1, 0, 1, 1);
    drain();

    // 6: reset mid-job with valid held, then a clean job restarts flag counting
    start_job(16'd3, 16'd1);
    stream(1, 2, 0, 1, 3, 1);
    prod_valid = 1'b1;
    prod_data = {LANES{16'd3}};
    #2;
    rst_n = 1'b0;
    #1;
    chk_b("t6_rst_valid", psum_valid, 1'b0);
    chk("t6_rst_data", psum_data, 32'd0);
    chk_b("t6_rst_inter", inter_end, 1'b0);
    chk_b("t6_rst_accum", accum_end, 1'b0);
    chk_b("t6_rst_busy", busy, 1'b0);
    chk_b("t6_rst_ready", prod_ready, 1'b0);
    q.delete();
    tick();
    prod_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk_b("t6_idle_busy", busy, 1'b0);
    start_job(16'd3, 16'd1);
    stream(1, 3, 0, 2, 3, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
